stack_op_sequencer: RTL

Sequencer that drives the stack pointer (increment/decrement/load controls) and the stack memory port, turning single-request stack operations (PUSH, POP, CALL, RET, LOAD_SP) into correctly ordered pointer and memory cycles. It sits between the instruction control unit and the stack-pointer/stack-memory datapath. It also tracks occupancy to flag overflow and underflow. After reset it initialises the pointer, which has no reset of its own.

---
 rtl/stack_op_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/stack_op_sequencer.sv
// Stack operation sequencer: turns single PUSH/POP/CALL/RET/LOAD_SP requests into
// ordered stack-pointer pulses and stack-memory cycles, and tracks stack occupancy.
module stack_op_sequencer #(
  parameter int STACK_DEPTH = 256,
  parameter int DEPTH_W     = 9
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [2:0]         op_code,
  input  logic [15:0]        op_data,
  output logic               I_SP,
  output logic               D_SP,
  output logic [7:0]         SP_input_Bus,
  output logic               mem_we,
  output logic               mem_re,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata,
  output logic [15:0]        result_data,
  output logic               result_valid,
  output logic               err_overflow,
  output logic               err_underflow,
  output logic [DEPTH_W-1:0] depth
);

  // state   | meaning
  // INIT    | load pointer with 0 (I_SP=D_SP=1), one cycle after reset
  // IDLE    | waiting for an operation, op_ready=1
  // PUSH    | write byte at pointer, increment
  // POP     | decrement, read byte at new top
  // POP_CAP | register popped byte into result_data
  // CALL_LO | write return address low byte, increment
  // CALL_HI | write return address high byte, increment
  // RET_HI  | decrement, read high byte
  // RET_LO  | decrement, read low byte, capture high byte
  // RET_CAP | register {high, low} into result_data
  // LOAD    | load pointer from op_data[7:0]
  localparam logic [3:0] ST_INIT    = 4'd0;
  localparam logic [3:0] ST_IDLE    = 4'd1;
  localparam logic [3:0] ST_PUSH    = 4'd2;
  localparam logic [3:0] ST_POP     = 4'd3;
  localparam logic [3:0] ST_POP_CAP = 4'd4;
  localparam logic [3:0] ST_CALL_LO = 4'd5;
  localparam logic [3:0] ST_CALL_HI = 4'd6;
  localparam logic [3:0] ST_RET_HI  = 4'd7;
  localparam logic [3:0] ST_RET_LO  = 4'd8;
  localparam logic [3:0] ST_RET_CAP = 4'd9;
  localparam logic [3:0] ST_LOAD    = 4'd10;

  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_LOAD = 3'd5;

  localparam logic [DEPTH_W-1:0] FULL_D   = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] CALL_LIM = DEPTH_W'(STACK_DEPTH - 2);
  localparam logic [DEPTH_W-1:0] ONE_D    = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] TWO_D    = DEPTH_W'(2);

  logic [3:0]  state, state_nxt;
  logic [15:0] data_q;
  logic [7:0]  hi_q;
  logic        accept;
  logic        full, call_full, push_rej, call_rej, pop_rej, ret_rej;
  logic        i_sp_dec, d_sp_dec;

  assign accept    = op_valid && (state == ST_IDLE);
  assign full      = (depth >= FULL_D);
  assign call_full = (depth > CALL_LIM);
  assign push_rej  = (op_code == OP_PUSH) && full;
  assign call_rej  = (op_code == OP_CALL) && call_full;
  assign pop_rej   = (op_code == OP_POP) && (depth == '0);
  assign ret_rej   = (op_code == OP_RET) && (depth < TWO_D);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:    state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_PUSH: if (!full)       state_nxt = ST_PUSH;
            OP_POP:  if (depth != '0) state_nxt = ST_POP;
            OP_CALL: if (!call_full)  state_nxt = ST_CALL_LO;
            OP_RET:  if (!ret_rej)    state_nxt = ST_RET_HI;
            OP_LOAD:                  state_nxt = ST_LOAD;
            default:                  state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_PUSH:    state_nxt = ST_IDLE;
      ST_POP:     state_nxt = ST_POP_CAP;
      ST_POP_CAP: state_nxt = ST_IDLE;
      ST_CALL_LO: state_nxt = ST_CALL_HI;
      ST_CALL_HI: state_nxt = ST_IDLE;
      ST_RET_HI:  state_nxt = ST_RET_LO;
      ST_RET_LO:  state_nxt = ST_RET_CAP;
      ST_RET_CAP: state_nxt = ST_IDLE;
      ST_LOAD:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= ST_INIT;
      data_q        <= '0;
      hi_q          <= '0;
      result_data   <= '0;
      result_valid  <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_nxt;
      result_valid  <= 1'b0;
      err_overflow  <= accept && (push_rej || call_rej);
      err_underflow <= accept && (pop_rej || ret_rej);
      if (accept)
        data_q <= op_data;
      if (state == ST_RET_LO)
        hi_q <= mem_rdata;
      if (state == ST_POP_CAP) begin
        result_data  <= {8'h00, mem_rdata};
        result_valid <= 1'b1;
      end
      if (state == ST_RET_CAP) begin
        result_data  <= {hi_q, mem_rdata};
        result_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      depth <= '0;
    end else begin
      case (state)
        ST_PUSH, ST_CALL_LO, ST_CALL_HI: depth <= depth + ONE_D;
        ST_POP, ST_RET_HI, ST_RET_LO:    depth <= depth - ONE_D;
        ST_LOAD:                         depth <= DEPTH_W'(data_q[7:0]);
        default:                         depth <= depth;
      endcase
    end
  end

  // Pointer controls are pure state decodes; INIT would otherwise show a load
  // while reset is held, so they are also forced low by RST_N.
  always_comb begin
    i_sp_dec = 1'b0;
    d_sp_dec = 1'b0;
    case (state)
      ST_INIT, ST_LOAD: begin
        i_sp_dec = 1'b1;
        d_sp_dec = 1'b1;
      end
      ST_PUSH, ST_CALL_LO, ST_CALL_HI: i_sp_dec = 1'b1;
      ST_POP, ST_RET_HI, ST_RET_LO:    d_sp_dec = 1'b1;
      default: ;
    endcase
  end

  assign I_SP = i_sp_dec & RST_N;
  assign D_SP = d_sp_dec & RST_N;

  assign op_ready     = (state == ST_IDLE);
  assign SP_input_Bus = (state == ST_LOAD) ? data_q[7:0] : 8'h00;
  assign mem_we       = (state == ST_PUSH) || (state == ST_CALL_LO) || (state == ST_CALL_HI);
  assign mem_re       = (state == ST_POP) || (state == ST_RET_HI) || (state == ST_RET_LO);

  always_comb begin
    mem_wdata = 8'h00;
    case (state)
      ST_PUSH, ST_CALL_LO: mem_wdata = data_q[7:0];
      ST_CALL_HI:          mem_wdata = data_q[15:8];
      default:             mem_wdata = 8'h00;
    endcase
  end

endmodule
